bdi_packet_compressor: RTL
==========================

# bdi_packet_compressor

Packet-level base-delta flit compressor for the NoC injection path, the parametrised successor of the single-body-flit compressor. It accepts one packet (a head flit plus up to MAX_BODY body flits) over a valid/ready handshake and computes a base and an encoding class per body flit. It drops body flits whose chunks are all equal, writes per-flit metadata into the head flit, and emits the head followed by the surviving compressed body flits. Output is registered and never driven to high impedance.

## Interface
- FLIT_WIDTH, 128, flit width; must be a multiple of CHUNK_SIZE.
- CHUNK_SIZE, 8, chunk width; NUM_CHUNKS = FLIT_WIDTH/CHUNK_SIZE.
- EN_BITS, 4, encoding-class width; must satisfy 2^EN_BITS-1 >= CHUNK_SIZE.
- MAX_BODY, 4, maximum body flits per packet; this is also the body-buffer depth.
- META_MSB, 74, MSB of metadata slot 0 in the head flit.
- CNT_W, 3, width of the body-count field; requires 2^CNT_W > MAX_BODY.
- clk_in  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input flit valid.
- in_ready  output  1  block can accept a flit.
- in_is_head  input  1  flit is a head.
- in_is_tail  input  1  flit is the last of its packet; head and tail together mark a head-only packet.
- data_in  input  FLIT_WIDTH  input flit.
- out_valid  output  1  data_out valid.
- out_ready  input  1  downstream accepts.
- out_is_head  output  1  emitted flit is the head.
- out_is_tail  output  1  emitted flit is the last flit of the packet.
- data_out  output  FLIT_WIDTH  emitted flit.
- proto_err  output  1  sticky protocol-error flag; cleared only by reset.

## Operation
- States and transitions:
  - IDLE, on accepting a head: go to COLLECT, or to EMIT_HEAD if in_is_tail is set.
  - COLLECT, on accepting a body: go to EMIT_HEAD when in_is_tail is set, otherwise stay in COLLECT.
  - EMIT_HEAD, on an out handshake: go to EMIT_BODY if the buffer is non-empty, else to IDLE.
  - EMIT_BODY: on the handshake of the last buffered entry, go to IDLE.
- in_ready is 1 in IDLE and COLLECT and 0 in both EMIT states.
- Accepting a head: copy it into the head register, set body index k=0, and zero every metadata slot plus the count field.
- Per accepted body flit k, split the flit into chunks with c1 = data_in[FLIT_WIDTH-1 -: CHUNK_SIZE]; all chunk arithmetic is unsigned.
  - max and min are taken over all chunks.
  - base = (max+min)>>1, computed at CHUNK_SIZE+1 bits then truncated.
  - r = max-min; en = bit length of r, so en=0 when r=0 and en ranges 1..CHUNK_SIZE.
- Slot write: head[META_MSB - k*(EN_BITS+CHUNK_SIZE) -: EN_BITS+CHUNK_SIZE] = {en, base}.
- Flit handling by en:
  - en=0: the flit is dropped and not buffered.
  - 1 <= en < CHUNK_SIZE: buffer the flit as deltas d_i = c_i - base mod 2^CHUNK_SIZE, in the same chunk order.
  - en=CHUNK_SIZE (raw mode): buffer data_in unchanged.
- After each body flit, k increments.
- On the tail, write k into the count field head[META_MSB+CNT_W -: CNT_W].
- Body before head: in IDLE, a flit with in_is_head=0 is accepted and dropped, and proto_err is set.
- Head in COLLECT: the head is accepted and dropped, proto_err is set, and the current packet continues.
- Overflow: a body flit arriving when k=MAX_BODY is dropped and proto_err is set; if that flit carries in_is_tail, the packet still closes normally.
- Tail marking:
  - out_is_tail is set on the last buffered entry.
  - If the buffer is empty, out_is_tail is set on the head.
  - out_is_head is set only in EMIT_HEAD.

## Timing
- Reset:
  - State goes to IDLE.
  - out_valid, out_is_head, out_is_tail, proto_err, the buffer, k and the head register all clear to 0.
  - data_out resets to 0.
  - in_ready is 1 once reset deasserts.
- Reset mid-packet discards the packet entirely; nothing is emitted afterward.
- Latency: out_valid rises with the head the cycle after the tail handshake.
- Body flits are emitted back-to-back, one per cycle while out_ready=1, with no bubbles because dropped flits are never buffered.
- While out_valid=1 and out_ready=0, data_out and the flags hold stable.
- The block is never ready on both sides in one cycle: in_ready=0 whenever out_valid=1.
- The buffer pointer wraps at MAX_BODY; a full buffer is reachable only with k=MAX_BODY.

## Test plan
- Head-only packet H (in_is_head=1, in_is_tail=1) -> one cycle later: out_valid=1, out_is_head=1, out_is_tail=1, count field=0, all slots 0.
- Head plus one body of sixteen 0x55 chunks (tail) -> the body is dropped.
  - Slot 0 holds {en=0, base=0x55}, count=1.
  - Only the head is emitted, with out_is_tail=1.
- Body with chunks 0x10..0x1F ascending -> max=0x1F, min=0x10, base=0x17, en=4.
  - Emitted body chunks are 0xF9, 0xFA, ..., 0x08.
  - The body has out_is_tail=1.
- Body containing 0x00 and 0xFF -> en=8, base=0x7F, and the body is emitted as data_in unchanged.
- Three compressible bodies with out_ready toggled 1,0,0,1,... -> each flit holds stable until its handshake.
  - Order is head, b0, b1, b2; in_ready stays 0 until the last handshake.
- Five body flits with MAX_BODY=4 -> the fifth is dropped, proto_err=1, count=4.
  - Apply rst_n=0 mid-emit -> outputs clear at once and proto_err returns to 0.

Source files
------------

// File: rtl/bdi_packet_compressor.sv
// Purpose : packet-level base-delta compressor; one head plus up to MAX_BODY body flits in, head plus surviving compressed bodies out.
// Latency : the head is presented on data_out the cycle after the tail handshake; bodies follow back-to-back.
// Backpr. : in_ready drops for the whole emit phase; the registered output holds stable while out_ready=0.
//
// Ports:
//   clk_in, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          input handshake; in_is_head/in_is_tail frame the packet on data_in
//   out_valid/out_ready        output handshake; out_is_head/out_is_tail frame the packet on data_out
//   proto_err                  sticky protocol-error flag, cleared only by reset
module bdi_packet_compressor #(
  parameter int FLIT_WIDTH = 128,
  parameter int CHUNK_SIZE = 8,
  parameter int EN_BITS    = 4,
  parameter int MAX_BODY   = 4,
  parameter int META_MSB   = 74,
  parameter int CNT_W      = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_head,
  input  logic                  in_is_tail,
  input  logic [FLIT_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_is_head,
  output logic                  out_is_tail,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic                  proto_err
);

  localparam int NUM_CHUNKS = FLIT_WIDTH / CHUNK_SIZE;
  localparam int SLOT_W     = EN_BITS + CHUNK_SIZE;
  localparam int PTR_W      = (MAX_BODY > 1) ? $clog2(MAX_BODY) : 1;
  // Lowest bit of the metadata region (count field plus all slots).
  localparam int META_LSB   = META_MSB - MAX_BODY * SLOT_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1,
    EMIT_HEAD = 2'd2,
    EMIT_BODY = 2'd3
  } state_t;

  state_t state_q, state_nxt;

  logic [FLIT_WIDTH-1:0] head_q, head_nxt;
  logic [CNT_W-1:0]      k_q, k_nxt;
  logic [FLIT_WIDTH-1:0] buf_mem [MAX_BODY];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      buf_cnt, buf_cnt_nxt;

  // Per-flit chunk analysis
  logic [CHUNK_SIZE-1:0] chunk_max, chunk_min, base, range_r;
  logic [EN_BITS-1:0]    en;
  logic [FLIT_WIDTH-1:0] delta_flit, body_store;

  // Input-side decode
  logic acc, acc_head, acc_body, slot_ok, buf_wr, pkt_close, err_set;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM: next state and in_ready. out_valid is always 1 in the emit states,
  // so out_ready alone marks an output handshake there.
  always_comb begin
    state_nxt = state_q;
    in_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_is_head) begin
          state_nxt = in_is_tail ? EMIT_HEAD : COLLECT;
        end
      end
      COLLECT: begin
        in_ready = 1'b1;
        // A stray head inside a packet never closes it, even if tagged tail.
        if (in_valid && !in_is_head && in_is_tail) begin
          state_nxt = EMIT_HEAD;
        end
      end
      EMIT_HEAD: begin
        if (out_ready) begin
          state_nxt = (buf_cnt != '0) ? EMIT_BODY : IDLE;
        end
      end
      EMIT_BODY: begin
        // buf_cnt counts entries not yet loaded onto data_out, so zero here
        // means the flit currently shown is the last one.
        if (out_ready && (buf_cnt == '0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Chunk analysis: c1 is the most significant chunk. All arithmetic unsigned.
  // ---------------------------------------------------------------------------
  always_comb begin
    chunk_max  = '0;
    chunk_min  = '1;
    delta_flit = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (data_in[FLIT_WIDTH-1-i*CHUNK_SIZE -: CHUNK_SIZE] > chunk_max) begin
        chunk_max = data_in[FLIT_WIDTH-1-i*CHUNK_SIZE -: CHUNK_SIZE];
      end
      if (data_in[FLIT_WIDTH-1-i*CHUNK_SIZE -: CHUNK_SIZE] < chunk_min) begin
        chunk_min = data_in[FLIT_WIDTH-1-i*CHUNK_SIZE -: CHUNK_SIZE];
      end
    end

    // Midpoint needs one extra bit so the sum cannot overflow before the shift.
    base    = CHUNK_SIZE'(({1'b0, chunk_max} + {1'b0, chunk_min}) >> 1);
    range_r = chunk_max - chunk_min;

    // en is the bit length of the range: position of the highest set bit + 1.
    en = '0;
    for (int b = 0; b < CHUNK_SIZE; b++) begin
      if (range_r[b]) begin
        en = EN_BITS'(b + 1);
      end
    end

    // Deltas wrap modulo 2^CHUNK_SIZE, same chunk order as the input.
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      delta_flit[FLIT_WIDTH-1-i*CHUNK_SIZE -: CHUNK_SIZE] =
        data_in[FLIT_WIDTH-1-i*CHUNK_SIZE -: CHUNK_SIZE] - base;
    end

    // A full-width range gains nothing from deltas: keep the flit raw.
    body_store = (en == EN_BITS'(CHUNK_SIZE)) ? data_in : delta_flit;
  end

  // ---------------------------------------------------------------------------
  // Input decode and head-flit metadata update
  // ---------------------------------------------------------------------------
  always_comb begin
    acc       = in_valid && in_ready;
    acc_head  = acc && in_is_head && (state_q == IDLE);
    acc_body  = acc && !in_is_head && (state_q == COLLECT);
    slot_ok   = (k_q < CNT_W'(MAX_BODY));
    buf_wr    = acc_body && slot_ok && (en != '0);
    pkt_close = (acc_head || acc_body) && in_is_tail;
    // Three error cases: body while idle, head mid-packet, body past capacity.
    err_set   = (acc && (state_q == IDLE) && !in_is_head) ||
                (acc && (state_q == COLLECT) && in_is_head) ||
                (acc_body && !slot_ok);

    k_nxt = k_q;
    if (acc_head) begin
      k_nxt = '0;
    end else if (acc_body && slot_ok) begin
      k_nxt = k_q + CNT_W'(1);
    end

    buf_cnt_nxt = buf_cnt;
    if (acc_head) begin
      buf_cnt_nxt = '0;
    end else if (buf_wr) begin
      buf_cnt_nxt = buf_cnt + CNT_W'(1);
    end

    head_nxt = head_q;
    if (acc_head) begin
      head_nxt = data_in;
      head_nxt[META_MSB+CNT_W:META_LSB] = '0;
    end else if (acc_body && slot_ok) begin
      // Dropped (en=0) flits still record their slot so the base survives.
      for (int s = 0; s < MAX_BODY; s++) begin
        if (k_q == CNT_W'(s)) begin
          head_nxt[META_MSB-s*SLOT_W -: SLOT_W] = {en, base};
        end
      end
    end
    if (pkt_close) begin
      head_nxt[META_MSB+CNT_W -: CNT_W] = k_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: head register, body buffer, registered output stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      k_q         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      buf_cnt     <= '0;
      for (int i = 0; i < MAX_BODY; i++) begin
        buf_mem[i] <= '0;
      end
      out_valid   <= 1'b0;
      out_is_head <= 1'b0;
      out_is_tail <= 1'b0;
      data_out    <= '0;
      proto_err   <= 1'b0;
    end else begin
      head_q <= head_nxt;
      k_q    <= k_nxt;

      if (err_set) begin
        proto_err <= 1'b1;
      end

      if (acc_head) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        buf_cnt <= '0;
      end else if (buf_wr) begin
        buf_mem[wr_ptr] <= body_store;
        wr_ptr          <= (wr_ptr == PTR_W'(MAX_BODY - 1)) ? '0 : wr_ptr + PTR_W'(1);
        buf_cnt         <= buf_cnt_nxt;
      end

      // Input and output phases never overlap: in_ready is 0 while out_valid=1.
      if (pkt_close) begin
        out_valid   <= 1'b1;
        out_is_head <= 1'b1;
        out_is_tail <= (buf_cnt_nxt == '0);
        data_out    <= head_nxt;
      end else if (out_valid && out_ready) begin
        if (buf_cnt != '0) begin
          data_out    <= buf_mem[rd_ptr];
          out_is_head <= 1'b0;
          out_is_tail <= (buf_cnt == CNT_W'(1));
          rd_ptr      <= (rd_ptr == PTR_W'(MAX_BODY - 1)) ? '0 : rd_ptr + PTR_W'(1);
          buf_cnt     <= buf_cnt - CNT_W'(1);
        end else begin
          out_valid   <= 1'b0;
          out_is_head <= 1'b0;
          out_is_tail <= 1'b0;
        end
      end
    end
  end

endmodule
